// File: rtl/simd_pkg.sv
// Shared opcodes, lane-mode encodings and the saturating-add helper for the SIMD execute stage.
package simd_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 5;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_ADDS = 4'd2;
  localparam logic [3:0] OP_SUBS = 4'd3;
  localparam logic [3:0] OP_MUL  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_XOR  = 4'd7;
  localparam logic [3:0] OP_SLL  = 4'd8;
  localparam logic [3:0] OP_SRL  = 4'd9;
  localparam logic [3:0] OP_SRA  = 4'd10;
  localparam logic [3:0] OP_MAX  = 4'd11;
  localparam logic [3:0] OP_MIN  = 4'd12;

  localparam logic [1:0] LM_1X16 = 2'd0;
  localparam logic [1:0] LM_2X8  = 2'd1;
  localparam logic [1:0] LM_4X4  = 2'd2;

  // Signed value of the low w bits of v.
  function automatic int lane_sext(input logic [15:0] v, input int unsigned w);
    int x;
    x = int'({16'h0000, v}) & ((1 << w) - 1);
    if (x >= (1 << (w - 1))) x = x - (1 << w);
    return x;
  endfunction

  // Unclamped signed sum/difference of two w-bit lanes.
  function automatic int lane_sum(input logic [15:0] a, input logic [15:0] b,
                                  input int unsigned w, input logic sub);
    int sa, sb;
    sa = lane_sext(a, w);
    sb = lane_sext(b, w);
    return sub ? (sa - sb) : (sa + sb);
  endfunction

  // Saturating w-bit add (or subtract); result in the low w bits.
  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b,
                                          input int unsigned w, input logic sub);
    int s;
    logic [31:0] r;
    s = lane_sum(a, b, w, sub);
    if (s > ((1 << (w - 1)) - 1)) s = (1 << (w - 1)) - 1;
    else if (s < -(1 << (w - 1))) s = -(1 << (w - 1));
    r = 32'(s);
    return r[15:0];
  endfunction

  // Overflow indication matching sat_add.
  function automatic logic sat_add_ovf(input logic [15:0] a, input logic [15:0] b,
                                       input int unsigned w, input logic sub);
    int s;
    s = lane_sum(a, b, w, sub);
    return (s > ((1 << (w - 1)) - 1)) || (s < -(1 << (w - 1)));
  endfunction

endpackage

// File: rtl/simd_lane_alu.sv
// Combinational single-lane ALU of width W; nothing crosses the lane boundary.
module simd_lane_alu
  import simd_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [3:0]   op,
  output logic [W-1:0] y,
  output logic         sat
);

  localparam int unsigned SH_W = $clog2(W);

  logic [SH_W-1:0] shamt;

  assign shamt = b[SH_W-1:0];

  // Lane operation select; reserved codes produce zero.
  always_comb begin
    y   = '0;
    sat = 1'b0;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_ADDS: begin
        y   = W'(sat_add(16'(a), 16'(b), W, 1'b0));
        sat = sat_add_ovf(16'(a), 16'(b), W, 1'b0);
      end
      OP_SUBS: begin
        y   = W'(sat_add(16'(a), 16'(b), W, 1'b1));
        sat = sat_add_ovf(16'(a), 16'(b), W, 1'b1);
      end
      OP_MUL:  y = a * b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_SLL:  y = a << shamt;
      OP_SRL:  y = a >> shamt;
      OP_SRA:  y = $unsigned($signed(a) >>> shamt);
      OP_MAX:  y = ($signed(a) > $signed(b)) ? a : b;
      OP_MIN:  y = ($signed(a) < $signed(b)) ? a : b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/simd_exec_stage.sv
// Two-stage valid/ready SIMD execute stage feeding the register-file write port.
module simd_exec_stage
  import simd_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op,
  input  logic [1:0]        lane_mode,
  input  logic [ADDR_W-1:0] rd_in,
  input  logic [DATA_W-1:0] rs1_data,
  input  logic [DATA_W-1:0] rs2_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              rd_wr_en,
  output logic [ADDR_W-1:0] rd,
  output logic [DATA_W-1:0] wr_data,
  output logic              sat_flag,
  output logic              illegal
);

  logic              s1_valid;
  logic [3:0]        s1_op;
  logic [1:0]        s1_lm;
  logic [ADDR_W-1:0] s1_rd;
  logic [DATA_W-1:0] s1_a, s1_b;

  logic              s2_load, accept;
  logic [DATA_W-1:0] y16, y8, y4, res_c;
  logic              sat16, sat_c, illegal_c;
  logic [1:0]        sat8;
  logic [3:0]        sat4;

  assign s2_load  = s1_valid & (~out_valid | out_ready);
  assign in_ready = ~s1_valid | s2_load;
  assign accept   = in_valid & in_ready;
  assign rd_wr_en = out_valid & out_ready & (rd != '0);

  simd_lane_alu #(.W(16)) u_lane16 (
    .a(s1_a), .b(s1_b), .op(s1_op), .y(y16), .sat(sat16)
  );

  for (genvar g = 0; g < 2; g++) begin : g_lane8
    simd_lane_alu #(.W(8)) u_lane (
      .a(s1_a[8*g +: 8]), .b(s1_b[8*g +: 8]), .op(s1_op),
      .y(y8[8*g +: 8]), .sat(sat8[g])
    );
  end

  for (genvar g = 0; g < 4; g++) begin : g_lane4
    simd_lane_alu #(.W(4)) u_lane (
      .a(s1_a[4*g +: 4]), .b(s1_b[4*g +: 4]), .op(s1_op),
      .y(y4[4*g +: 4]), .sat(sat4[g])
    );
  end

  // Lane-mode mux; illegal encodings force a zero result with no saturation.
  always_comb begin
    res_c     = '0;
    sat_c     = 1'b0;
    illegal_c = (s1_op > OP_MIN) || (s1_lm == 2'd3);
    case (s1_lm)
      LM_1X16: begin res_c = y16; sat_c = sat16; end
      LM_2X8:  begin res_c = y8;  sat_c = |sat8; end
      LM_4X4:  begin res_c = y4;  sat_c = |sat4; end
      default: begin res_c = '0;  sat_c = 1'b0;  end
    endcase
    if (illegal_c) begin
      res_c = '0;
      sat_c = 1'b0;
    end
  end

  // S1: operand capture on issue handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_lm    <= '0;
      s1_rd    <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_op    <= op;
      s1_lm    <= lane_mode;
      s1_rd    <= rd_in;
      s1_a     <= rs1_data;
      s1_b     <= rs2_data;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  // S2: result register; holds while the writeback is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      rd        <= '0;
      wr_data   <= '0;
      sat_flag  <= 1'b0;
      illegal   <= 1'b0;
    end else if (s2_load) begin
      out_valid <= 1'b1;
      rd        <= s1_rd;
      wr_data   <= res_c;
      sat_flag  <= sat_c;
      illegal   <= illegal_c;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_simd_exec_stage.sv
// Scoreboard bench for simd_exec_stage against an integer lane-arithmetic model.
module tb_simd_exec_stage;

  typedef struct packed {
    logic [4:0]  rd;
    logic [15:0] data;
    logic        sat;
    logic        ill;
  } exp_t;

  logic        clk, rst;
  logic        in_valid, in_ready, out_valid, out_ready, rd_wr_en;
  logic        sat_flag, illegal;
  logic [3:0]  op;
  logic [1:0]  lane_mode;
  logic [4:0]  rd_in, rd;
  logic [15:0] rs1_data, rs2_data, wr_data;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_acc    = 0;
  int   stalls   = 0;
  logic rand_ready = 1'b0;

  simd_exec_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .lane_mode(lane_mode), .rd_in(rd_in),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .out_valid(out_valid), .out_ready(out_ready), .rd_wr_en(rd_wr_en),
    .rd(rd), .wr_data(wr_data), .sat_flag(sat_flag), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: split into lanes, do signed/unsigned integer arithmetic, repack.
  function automatic exp_t model(input logic [3:0] o, input logic [1:0] lm,
                                 input logic [4:0] r_d, input logic [15:0] a,
                                 input logic [15:0] b);
    exp_t e;
    int w, n, mask, hi, lo, ai, bi, sa, sb, sh, r;
    e = '0;
    e.rd = r_d;
    if (lm == 2'd3 || o > 4'd12) begin
      e.ill = 1'b1;
      return e;
    end
    w = 16 >> lm;
    n = 16 / w;
    mask = (1 << w) - 1;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    for (int i = 0; i < n; i++) begin
      ai = (int'(a) >> (w * i)) & mask;
      bi = (int'(b) >> (w * i)) & mask;
      sa = (ai > hi) ? ai - (1 << w) : ai;
      sb = (bi > hi) ? bi - (1 << w) : bi;
      sh = bi % w;
      case (o)
        4'd0:  r = sa + sb;
        4'd1:  r = sa - sb;
        4'd2, 4'd3: begin
          r = (o == 4'd2) ? sa + sb : sa - sb;
          if (r > hi) begin r = hi; e.sat = 1'b1; end
          else if (r < lo) begin r = lo; e.sat = 1'b1; end
        end
        4'd4:  r = sa * sb;
        4'd5:  r = ai & bi;
        4'd6:  r = ai | bi;
        4'd7:  r = ai ^ bi;
        4'd8:  r = ai << sh;
        4'd9:  r = ai >> sh;
        4'd10: r = sa >>> sh;
        4'd11: r = (sa > sb) ? sa : sb;
        default: r = (sa < sb) ? sa : sb;
      endcase
      e.data = e.data | 16'((r & mask) << (w * i));
    end
    return e;
  endfunction

  // Drive one issue and hold it until the handshake completes.
  task automatic issue(input logic [3:0] o, input logic [1:0] lm, input logic [4:0] r_d,
                       input logic [15:0] a, input logic [15:0] b);
    logic rdy;
    int   waitc;
    op = o; lane_mode = lm; rd_in = r_d; rs1_data = a; rs2_data = b;
    in_valid = 1'b1;
    waitc = 0;
    rdy = 1'b0;
    while (!rdy && waitc <= 200) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (!rdy) begin
        waitc++;
        stalls++;
      end
    end
    if (rdy) begin
      sb_q.push_back(model(o, lm, r_d, a, b));
      n_acc++;
    end else begin
      chk("issue_timeout", 32'(waitc), 32'd0);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int c = 0;
    while ((sb_q.size() != 0 || out_valid) && c < 200) begin
      @(posedge clk);
      c++;
    end
    #1;
    chk("drain_empty", 32'(sb_q.size()), 32'd0);
  endtask

  // Monitor: pops on every writeback handshake; also checks hold stability.
  logic        held = 1'b0;
  logic [22:0] held_v;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      held = 1'b0;
      if (rd_wr_en) chk("rst_wr_en", 32'(rd_wr_en), 32'd0);
    end else begin
      if (held && out_valid) chk("hold_stable", 32'({rd, wr_data, sat_flag, illegal}), 32'(held_v));
      held   = out_valid && !out_ready;
      held_v = {rd, wr_data, sat_flag, illegal};
      if (out_valid && !out_ready) chk("wr_en_stall", 32'(rd_wr_en), 32'd0);
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("rd", 32'(rd), 32'(e.rd));
          chk("wr_data", 32'(wr_data), 32'(e.data));
          chk("sat_flag", 32'(sat_flag), 32'(e.sat));
          chk("illegal", 32'(illegal), 32'(e.ill));
          chk("rd_wr_en", 32'(rd_wr_en), 32'(e.rd != 5'd0));
        end
      end
    end
  end

  // Random writeback backpressure when enabled.
  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; lane_mode = '0; rd_in = '0; rs1_data = '0; rs2_data = '0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_rd", 32'(rd), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_sat", 32'(sat_flag), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_wr_en", 32'(rd_wr_en), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset mid-flight: two ops in flight are discarded.
    issue(4'd0, 2'd0, 5'd1, 16'h1111, 16'h2222);
    issue(4'd0, 2'd0, 5'd2, 16'h3333, 16'h4444);
    chk("mf_out_valid_pre", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mf_out_valid", 32'(out_valid), 32'd0);
    chk("mf_wr_en", 32'(rd_wr_en), 32'd0);
    chk("mf_in_ready", 32'(in_ready), 32'd1);
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;

    // Latency: visible one edge after the accepting edge, not at it.
    issue(4'd7, 2'd1, 5'd5, 16'hA5A5, 16'h0FF0);
    chk("lat_accept_edge", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("lat_next_edge", 32'(out_valid), 32'd1);
    drain();

    // Directed corner cases, back-to-back at full throughput.
    stalls = 0;
    issue(4'd0,  2'd1, 5'd3,  16'h80FF, 16'h8001);
    issue(4'd0,  2'd0, 5'd4,  16'h80FF, 16'h8001);
    issue(4'd2,  2'd2, 5'd6,  16'h7789, 16'h1118);
    issue(4'd2,  2'd2, 5'd7,  16'h1234, 16'h0000);
    issue(4'd3,  2'd1, 5'd8,  16'h8070, 16'h0190);
    issue(4'd10, 2'd1, 5'd9,  16'h8040, 16'h0302);
    issue(4'd4,  2'd1, 5'd10, 16'h0310, 16'h0510);
    issue(4'd0,  2'd0, 5'd0,  16'h1234, 16'h1111);
    issue(4'd14, 2'd0, 5'd11, 16'hFFFF, 16'h0001);
    issue(4'd0,  2'd3, 5'd12, 16'hFFFF, 16'h0001);
    chk("full_throughput_stalls", 32'(stalls), 32'd0);
    drain();

    // Backpressure: two accepts fill the pipe, then in_ready drops.
    out_ready = 1'b0;
    n_acc = 0;
    fork
      begin
        for (int i = 0; i < 4; i++)
          issue(4'(i), 2'd2, 5'(20 + i), 16'($urandom), 16'($urandom));
      end
      begin
        repeat (3) @(posedge clk);
        #2;
        chk("bp_accepts", 32'(n_acc), 32'd2);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
      end
    join
    drain();

    // Randomized traffic with random backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic [1:0] lm;
      lm = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      issue(4'($urandom_range(0, 15)), lm, 5'($urandom), 16'($urandom), 16'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #2 out_ready = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
